ped_crossing_ctrl: RTL and testbench

PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

---
 rtl/ped_crossing_ctrl_pkg.sv | 35 +++
 rtl/ped_crossing_ctrl_seven_segment.sv | 17 +
 rtl/ped_crossing_ctrl.sv | 156 +++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_crossing_ctrl_pkg.sv
// Shared definitions for the pedestrian crossing controller:
// FSM state enumeration, blank segment pattern and the digit-to-segment
// encoder used by the seven_segment decoder.
package ped_crossing_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Active-high segments, bit order {g,f,e,d,c,b,a}; non-decimal values blank.
    function automatic logic [6:0] seg_encode(input logic [4:0] digit);
        logic [6:0] seg;
        case (digit)
            5'd0:    seg = 7'h3F;
            5'd1:    seg = 7'h06;
            5'd2:    seg = 7'h5B;
            5'd3:    seg = 7'h4F;
            5'd4:    seg = 7'h66;
            5'd5:    seg = 7'h6D;
            5'd6:    seg = 7'h7D;
            5'd7:    seg = 7'h07;
            5'd8:    seg = 7'h7F;
            5'd9:    seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ped_crossing_ctrl_seven_segment.sv
// Two-digit seven-segment decoder for a 0..31 seconds value.
// Purely combinational; leading zero is shown.
module seven_segment
    import ped_crossing_ctrl_pkg::*;
(
    input  logic [4:0] value,
    output logic [6:0] tens,
    output logic [6:0] ones
);

    // Split the value into decimal digits and encode each one.
    always_comb begin
        tens = seg_encode(value / 5'd10);
        ones = seg_encode(value % 5'd10);
    end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: latches a push-button request, waits for
// the vehicle controller's grant, then runs WALK (steady walk lamp) and
// CLEAR (countdown on two seven-segment digits) before pulsing phase_done.
// Optional feature macro: PED_HAND_FLASH_EN -- when defined the don't-walk
// lamp flashes during CLEAR (on for the first half of each second);
// otherwise it is steady on during CLEAR.
module ped_crossing_ctrl
    import ped_crossing_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int WALK_TIME  = 10,
    parameter int CLEAR_TIME = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_request,
    input  logic       phase_grant,
    output logic       req_pending,
    output logic       phase_done,
    output logic       busy,
    output logic       walk_light,
    output logic       hand_light,
    output logic [6:0] tens_digit,
    output logic [6:0] ones_digit
);

    localparam int PW = $clog2(TICK_DIV);

    // Reject parameter values the counters cannot represent.
    if (TICK_DIV < 2 || (TICK_DIV % 2) != 0) begin : g_bad_tick_div
        $error("ped_crossing_ctrl: TICK_DIV must be even and >= 2");
    end
    if (WALK_TIME < 1 || WALK_TIME > 63) begin : g_bad_walk_time
        $error("ped_crossing_ctrl: WALK_TIME must be in 1..63");
    end
    if (CLEAR_TIME < 1 || CLEAR_TIME > 31) begin : g_bad_clear_time
        $error("ped_crossing_ctrl: CLEAR_TIME must be in 1..31");
    end

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [5:0]    secs;
    logic          sec_tick;
    logic          last_sec;
    logic          show_digits;
    logic [6:0]    seg_tens;
    logic [6:0]    seg_ones;

    assign sec_tick = (presc == PW'(TICK_DIV - 1));
    assign last_sec = sec_tick && (secs == 6'd1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and lamp/status decode from the registered state.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        walk_light  = 1'b0;
        hand_light  = 1'b1;
        phase_done  = 1'b0;
        show_digits = 1'b0;
        case (state)
            ST_IDLE: begin
                // Only a request already latched in an earlier cycle can start a phase.
                if (phase_grant && req_pending) begin
                    state_next = ST_WALK;
                end
            end
            ST_WALK: begin
                busy       = 1'b1;
                walk_light = 1'b1;
                hand_light = 1'b0;
                if (last_sec) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy        = 1'b1;
                show_digits = 1'b1;
`ifdef PED_HAND_FLASH_EN
                hand_light  = (presc < PW'(TICK_DIV / 2));
`else
                hand_light  = 1'b1;
`endif
                if (last_sec) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                phase_done = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One-second prescaler, restarted on every state change so each
    // phase starts on a whole-second boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (state_next != state || sec_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Seconds remaining in the current phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            secs <= '0;
        end else if (state_next == ST_WALK && state != ST_WALK) begin
            secs <= 6'(WALK_TIME);
        end else if (state_next == ST_CLEAR && state != ST_CLEAR) begin
            secs <= 6'(CLEAR_TIME);
        end else if (sec_tick && secs != 6'd0) begin
            secs <= secs - 6'd1;
        end
    end

    // Request latch: cleared when the phase starts, taking priority over a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pending <= 1'b0;
        end else if (state == ST_IDLE && state_next == ST_WALK) begin
            req_pending <= 1'b0;
        end else if (ped_request && (state == ST_IDLE || state == ST_CLEAR)) begin
            req_pending <= 1'b1;
        end
    end

    seven_segment u_seven_segment (
        .value (secs[4:0]),
        .tens  (seg_tens),
        .ones  (seg_ones)
    );

    // Digits are lit only during the clearance countdown.
    always_comb begin
        tens_digit = show_digits ? seg_tens : SEG_BLANK;
        ones_digit = show_digits ? seg_ones : SEG_BLANK;
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench for ped_crossing_ctrl (TICK_DIV=4, WALK_TIME=3, CLEAR_TIME=2).
module tb_ped_crossing_ctrl;

    localparam int TD  = 4;
    localparam int WT  = 3;
    localparam int CT  = 2;
    localparam int TOT = (WT + CT) * TD;
`ifdef PED_HAND_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ped_request = 1'b0;
    logic       phase_grant = 1'b0;
    logic       req_pending;
    logic       phase_done;
    logic       busy;
    logic       walk_light;
    logic       hand_light;
    logic [6:0] tens_digit;
    logic [6:0] ones_digit;

    int checks = 0;
    int failures = 0;

    ped_crossing_ctrl #(.TICK_DIV(TD), .WALK_TIME(WT), .CLEAR_TIME(CT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ped_request (ped_request),
        .phase_grant (phase_grant),
        .req_pending (req_pending),
        .phase_done  (phase_done),
        .busy        (busy),
        .walk_light  (walk_light),
        .hand_light  (hand_light),
        .tens_digit  (tens_digit),
        .ones_digit  (ones_digit)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10];

    // Reference model: a phase is a timeline of k cycles since WALK entry.
    bit m_active = 1'b0;
    int m_k = 0;
    bit m_pend = 1'b0;

    function automatic int m_region();
        if (!m_active)       return 0;
        if (m_k < WT * TD)   return 1;
        if (m_k < TOT)       return 2;
        return 3;
    endfunction

    function automatic logic [18:0] pack_exp(input logic b, input logic w, input logic h,
                                             input logic p, input logic d, input int s);
        logic [6:0] t;
        logic [6:0] o;
        t = (s < 0) ? 7'h00 : seg_tab[s / 10];
        o = (s < 0) ? 7'h00 : seg_tab[s % 10];
        return {b, w, h, p, d, t, o};
    endfunction

    function automatic logic [18:0] model_exp();
        int  r;
        int  c;
        logic h;
        int  s;
        r = m_region();
        h = 1'b1;
        s = -1;
        if (r == 1) h = 1'b0;
        if (r == 2) begin
            c = m_k - WT * TD;
            h = FLASH ? ((c % TD) < TD / 2) : 1'b1;
            s = CT - c / TD;
        end
        return pack_exp(r != 0, r == 1, h, m_pend, r == 3, s);
    endfunction

    task automatic model_edge(input logic r, input logic g);
        int reg0;
        reg0 = m_region();
        if (reg0 == 0 && m_pend && g) begin
            m_active = 1'b1;
            m_k = 0;
            m_pend = 1'b0;
        end else begin
            if ((reg0 == 0 || reg0 == 2) && r) m_pend = 1'b1;
            if (m_active) begin
                if (reg0 == 3) m_active = 1'b0;
                else m_k++;
            end
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {busy, walk_light, hand_light, req_pending, phase_done, tens_digit, ones_digit};
    endfunction

    task automatic check_vec(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare at the falling edge.
    task automatic step(input logic r, input logic g);
        ped_request = r;
        phase_grant = g;
        @(posedge clk);
        model_edge(r, g);
        @(negedge clk);
        check_vec("model", dut_vec(), model_exp());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ped_request = 1'b0;
        phase_grant = 1'b0;
        repeat (2) @(negedge clk);
        m_active = 1'b0;
        m_k = 0;
        m_pend = 1'b0;
        rst_n = 1'b1;
    endtask

    // Lamps must never be lit together.
    always @(negedge clk) begin
        if (rst_n && walk_light && hand_light) begin
            checks++;
            failures++;
            $display("FAIL lamp_exclusive: walk=%b hand=%b", walk_light, hand_light);
        end
    end

    typedef struct {
        logic r;
        logic g;
        int   n;
        logic b;
        logic w;
        logic h;
        logic p;
        logic d;
        int   s;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int nw;
        int nc;
        int nd;
        int cc;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        // Basic request/grant phase followed by grant-only idling.
        tbl.push_back('{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1});
        tbl.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1});
        tbl.push_back('{1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1});
        tbl.push_back('{1'b0, 1'b0, 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1});
        tbl.push_back('{1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2});
        tbl.push_back('{1'b0, 1'b0, 2,  1'b1, 1'b0, !FLASH, 1'b0, 1'b0, 2});
        tbl.push_back('{1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        tbl.push_back('{1'b0, 1'b0, 2,  1'b1, 1'b0, !FLASH, 1'b0, 1'b0, 1});
        tbl.push_back('{1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1});
        tbl.push_back('{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        tbl.push_back('{1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1});

        // Reset state.
        repeat (2) @(negedge clk);
        check_vec("reset_state", dut_vec(), pack_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1));
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                step(tbl[i].r, tbl[i].g);
                check_vec($sformatf("table_row%0d_cyc%0d", i, j), dut_vec(),
                          pack_exp(tbl[i].b, tbl[i].w, tbl[i].h, tbl[i].p, tbl[i].d, tbl[i].s));
            end
        end

        // Grant dropped in the fifth WALK cycle: phase still completes.
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        nw = 0; nc = 0; nd = 0;
        for (int i = 0; i < 40 && nd == 0; i++) begin
            if (walk_light) nw++;
            else if (busy && !phase_done) nc++;
            if (phase_done) nd++;
            if (nd == 0) step(1'b0, nw < 5);
        end
        check_int("grant_drop_walk_cycles", nw, 12);
        check_int("grant_drop_clear_cycles", nc, 8);
        check_int("grant_drop_done_pulses", nd, 1);
        step(1'b0, 1'b0);
        check_int("grant_drop_back_idle", busy, 0);

        // Request in WALK ignored, request in CLEAR cycle 3 kept for next phase.
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_int("walk_request_ignored", req_pending, 0);
        for (int i = 0; i < 20 && walk_light; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_int("clear_request_latched", req_pending, 1);
        for (int i = 0; i < 20 && !phase_done; i++) step(1'b0, 1'b0);
        check_int("clear_req_done_seen", phase_done, 1);
        step(1'b0, 1'b0);
        check_int("pending_after_done", req_pending, 1);
        check_int("idle_after_done", busy, 0);
        step(1'b0, 1'b1);
        check_int("second_walk_started", walk_light, 1);
        check_int("second_walk_pending_clr", req_pending, 0);

        // Asynchronous reset at CLEAR cycle 4.
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 20 && walk_light; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_int("reset_test_in_clear", (busy && !walk_light && !phase_done) ? 1 : 0, 1);
        #1 rst_n = 1'b0;
        #1 check_vec("async_reset_values", dut_vec(), pack_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1));
        cc = 0;
        repeat (3) begin
            @(negedge clk);
            if (phase_done) cc++;
        end
        check_int("no_done_during_reset", cc, 0);
        m_active = 1'b0;
        m_k = 0;
        m_pend = 1'b0;
        rst_n = 1'b1;
        step(1'b0, 1'b1);

        // Randomized request/grant traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
